// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared state encoding and port indices for the data-memory
//               arbiter (dmem_arbiter and arb_pick).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ACC_CPU = 2'd1;
    localparam state_t ACC_IO  = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    // Access state that serves a given port index.
    function automatic state_t acc_state(input logic port);
        acc_state = (port == PORT_IO) ? ACC_IO : ACC_CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Two-requester tie-break. Round-robin on last_grant when
//               DMEM_ARB_RR_EN is defined, otherwise CPU fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_io,
    input  logic last_grant,
    output logic winner
);

`ifdef DMEM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    always_comb begin
        if (req_cpu && req_io) begin
            winner = ~last_grant;
        end else if (req_io) begin
            winner = PORT_IO;
        end else begin
            winner = PORT_CPU;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    always_comb begin
        if (req_cpu) begin
            winner = PORT_CPU;
        end else if (req_io) begin
            winner = PORT_IO;
        end else begin
            winner = PORT_CPU;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Single-port data-memory arbiter between a CPU and an I/O
//               requester; one access per cycle, registered memory controls.
//               Define DMEM_ARB_RR_EN for round-robin tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
)
(
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_req_any;
    logic          w_winner;
    logic          w_last_grant;

    logic          r_cpu_gnt;
    logic          r_io_gnt;
    logic          r_cpu_rvalid;
    logic          r_io_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_io_rdata;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wd;

    logic          w_cpu_gnt_nxt;
    logic          w_io_gnt_nxt;
    logic          w_cpu_rvalid_nxt;
    logic          w_io_rvalid_nxt;
    logic [DW-1:0] w_cpu_rdata_nxt;
    logic [DW-1:0] w_io_rdata_nxt;
    logic          w_mem_we_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wd_nxt;

    assign w_req_any = cpu_req | io_req;

    arb_pick u_arb_pick (
        .req_cpu    (cpu_req),
        .req_io     (io_req),
        .last_grant (w_last_grant),
        .winner     (w_winner)
    );

`ifdef DMEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= PORT_IO;
        end else if (w_req_any) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = PORT_IO;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state: every state re-arbitrates, giving back-to-back access
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE, ACC_CPU, ACC_IO: begin
                w_state_nxt = w_req_any ? acc_state(w_winner) : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-values; the request is captured as it is granted
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_gnt_nxt  = (w_state_nxt == ACC_CPU);
        w_io_gnt_nxt   = (w_state_nxt == ACC_IO);
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_wd_nxt   = r_mem_wd;
        case (w_state_nxt)
            ACC_CPU: begin
                w_mem_we_nxt   = cpu_we;
                w_mem_addr_nxt = cpu_addr;
                w_mem_wd_nxt   = cpu_wdata;
            end
            ACC_IO: begin
                w_mem_we_nxt   = io_we;
                w_mem_addr_nxt = io_addr;
                w_mem_wd_nxt   = io_wdata;
            end
            default: begin
                w_mem_we_nxt   = 1'b0;
            end
        endcase

        // A read completes at the edge that ends its access cycle.
        w_cpu_rvalid_nxt = (r_state == ACC_CPU) && !r_mem_we;
        w_io_rvalid_nxt  = (r_state == ACC_IO)  && !r_mem_we;
        w_cpu_rdata_nxt  = w_cpu_rvalid_nxt ? mem_rd : r_cpu_rdata;
        w_io_rdata_nxt   = w_io_rvalid_nxt  ? mem_rd : r_io_rdata;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_gnt    <= 1'b0;
            r_io_gnt     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_io_rdata   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
        end else begin
            r_cpu_gnt    <= w_cpu_gnt_nxt;
            r_io_gnt     <= w_io_gnt_nxt;
            r_cpu_rvalid <= w_cpu_rvalid_nxt;
            r_io_rvalid  <= w_io_rvalid_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_io_rdata   <= w_io_rdata_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wd     <= w_mem_wd_nxt;
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign io_gnt     = r_io_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign io_rvalid  = r_io_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign io_rdata   = r_io_rdata;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wd     = r_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               memory, a transaction table and read-data scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          io_req, io_we, io_gnt, io_rvalid;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata, io_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] cpu_q[$];
    logic [7:0] io_q[$];
    logic [7:0] exp_c, exp_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_gnt     (io_gnt),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Read-data scoreboards: popped whenever the DUT reports rvalid.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_rvalid_unexpected actual=1 required=0");
                end else begin
                    exp_c = cpu_q.pop_front();
                    check("sb_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_c});
                end
            end
            if (io_rvalid) begin
                if (io_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL io_rvalid_unexpected actual=1 required=0");
                end else begin
                    exp_i = io_q.pop_front();
                    check("sb_io_rdata", {24'd0, io_rdata}, {24'd0, exp_i});
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_gnt",    {30'd0, cpu_gnt, io_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, cpu_rvalid, io_rvalid}, 32'd0);
        check("rst_mem",    {15'd0, mem_we, mem_addr, mem_wd}, 32'd0);
        check("rst_rdata",  {16'd0, cpu_rdata, io_rdata}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_access(input vec_t v);
        int   lat;
        logic got;
        if (v.port == 1'b0) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            io_req = 1'b1; io_we = v.we; io_addr = v.addr; io_wdata = v.wdata;
        end
        got = 1'b0;
        lat = 0;
        while (!got && lat < 4) begin
            @(posedge clk); #1;
            lat++;
            got = (v.port == 1'b0) ? cpu_gnt : io_gnt;
        end
        check("gnt_latency", lat, 1);
        if (got) begin
            check("other_gnt", {31'd0, (v.port == 1'b0) ? io_gnt : cpu_gnt}, 32'd0);
            check("acc_mem_we", {31'd0, mem_we}, {31'd0, v.we});
            check("acc_mem_addr", {24'd0, mem_addr}, {24'd0, v.addr});
            if (v.we) begin
                check("acc_mem_wd", {24'd0, mem_wd}, {24'd0, v.wdata});
                ref_mem[v.addr] = v.wdata;
            end else if (v.port == 1'b0) begin
                cpu_q.push_back(v.exp_rd);
            end else begin
                io_q.push_back(v.exp_rd);
            end
        end
        cpu_req = 1'b0;
        io_req  = 1'b0;
        @(posedge clk); #1;
        check("idle_mem_we", {31'd0, mem_we}, 32'd0);
        check("rvalid_pulse", {31'd0, (v.port == 1'b0) ? cpu_rvalid : io_rvalid},
              {31'd0, got && !v.we});
        check("other_rvalid", {31'd0, (v.port == 1'b0) ? io_rvalid : cpu_rvalid}, 32'd0);
        @(posedge clk); #1;
        check("rvalid_single", {30'd0, cpu_rvalid, io_rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[16] = 8'h5A; ref_mem[16] = 8'h5A;
        mem[48] = 8'h11; ref_mem[48] = 8'h11;

        //           port  we    addr   wdata  exp_rd
        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'hC3, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'hC3};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 8'h77, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h77};
        vecs[6] = '{1'b1, 1'b1, 8'h02, 8'hE8, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hE8};

        #1;
        apply_reset();

        for (int n = 0; n < 8; n++) begin
            do_access(vecs[n]);
        end

        // Both ports requesting continuously, from a fresh reset.
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        io_req  = 1'b1; io_we  = 1'b0; io_addr  = 8'h20;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (cpu_gnt) cpu_q.push_back(ref_mem[16]);
            if (io_gnt)  io_q.push_back(ref_mem[32]);
`ifdef DMEM_ARB_RR_EN
            check("tie_grant_rr", {30'd0, cpu_gnt, io_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
`else
            check("tie_grant_fixed", {30'd0, cpu_gnt, io_gnt}, 32'd2);
`endif
        end
        cpu_req = 1'b0;
        io_req  = 1'b0;
        @(posedge clk); #1;
        check("tie_grants_stop", {30'd0, cpu_gnt, io_gnt}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back CPU reads.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        @(posedge clk); #1;
        check("b2b_gnt1", {31'd0, cpu_gnt}, 32'd1);
        check("b2b_addr1", {24'd0, mem_addr}, 32'h01);
        cpu_q.push_back(ref_mem[1]);
        cpu_addr = 8'h02;
        @(posedge clk); #1;
        check("b2b_gnt2", {31'd0, cpu_gnt}, 32'd1);
        check("b2b_addr2", {24'd0, mem_addr}, 32'h02);
        check("b2b_rvalid1", {31'd0, cpu_rvalid}, 32'd1);
        check("b2b_rdata1", {24'd0, cpu_rdata}, {24'd0, ref_mem[1]});
        cpu_q.push_back(ref_mem[2]);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("b2b_gnt_off", {31'd0, cpu_gnt}, 32'd0);
        check("b2b_rvalid2", {31'd0, cpu_rvalid}, 32'd1);
        check("b2b_rdata2", {24'd0, cpu_rdata}, {24'd0, ref_mem[2]});
        @(posedge clk); #1;

        // Reset in the middle of an I/O write.
        io_req = 1'b1; io_we = 1'b1; io_addr = 8'h30; io_wdata = 8'h5F;
        @(posedge clk); #1;
        check("abort_gnt", {31'd0, io_gnt}, 32'd1);
        check("abort_we_before", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_we_drop", {31'd0, mem_we}, 32'd0);
        check("abort_gnt_drop", {31'd0, io_gnt}, 32'd0);
        check("abort_io_rdata", {24'd0, io_rdata}, 32'd0);
        check("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
        io_req = 1'b0; io_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_no_commit", {24'd0, mem[48]}, 32'h11);
        check("abort_no_rvalid", {31'd0, io_rvalid}, 32'd0);
        @(posedge clk); #1;
        check("abort_no_rvalid2", {31'd0, io_rvalid}, 32'd0);

        // CPU request that withdraws before any arbitration edge.
        io_req = 1'b1; io_we = 1'b0; io_addr = 8'h20;
        @(posedge clk); #1;
        check("withdraw_io_gnt", {31'd0, io_gnt}, 32'd1);
        io_q.push_back(ref_mem[32]);
        io_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h99;
        #3;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("withdraw_no_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("withdraw_no_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("withdraw_no_cpu_gnt2", {31'd0, cpu_gnt}, 32'd0);
        check("withdraw_mem_intact", {24'd0, mem[64]}, {24'd0, ref_mem[64]});
        @(posedge clk); #1;

        check("sb_cpu_drained", cpu_q.size(), 0);
        check("sb_io_drained", io_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 8, meaning the data memory address width.
REQ-002 The module SHALL have parameter DW, default 8, meaning the data memory word width.
REQ-003 The module SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The module SHALL have ports cpu_req, cpu_we  input  1 each  CPU access request and CPU write qualifier.
REQ-006 The module SHALL have ports cpu_addr  input  AW and cpu_wdata  input  DW  CPU address and CPU write data.
REQ-007 The module SHALL have ports cpu_gnt, cpu_rvalid  output  1 each, and cpu_rdata  output  DW  CPU grant, CPU read-valid and CPU read data.
REQ-008 The module SHALL have io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid and io_rdata, with the same directions and widths as the cpu_* ports, for the I/O requester.
REQ-009 The module SHALL have ports mem_we  output  1, mem_addr  output  AW and mem_wd  output  DW  driving the memory port, whose write commits on a clk edge.
REQ-010 The module SHALL have port mem_rd  input  DW  combinational memory read data for mem_addr.

Function
REQ-011 The FSM SHALL have the states IDLE, ACC_CPU and ACC_IO, held in a state register.
REQ-012 Arbitration in IDLE:
- Samples cpu_req and io_req at the clk edge.
- No request -> stays in IDLE.
- One request -> goes to that requester's ACC_* state.
- Both requests -> goes to the state selected by the priority rule (REQ-023/024).
REQ-013 In ACC_x, the outputs SHALL be registered: x_gnt=1 for exactly one cycle, mem_addr/mem_wd from the granted port, and mem_we equal to the granted x_we.
REQ-014 The granted requester SHALL hold req, we, addr and wdata stable until it sees gnt.
REQ-015 The arbiter SHALL capture addr, we and wdata into internal registers at the arbitration edge, so that mem_* outputs are stable throughout ACC_x.
REQ-016 For a read in ACC_x, the arbiter SHALL register mem_rd into x_rdata at the end of ACC_x and assert x_rvalid for exactly one cycle.
- Request-to-gnt latency: 1 cycle.
- Request-to-rvalid latency: 2 cycles.
REQ-017 A write in ACC_x SHALL commit at the edge ending ACC_x, with x_rvalid held at 0 and x_rdata unchanged.
REQ-018 From ACC_x, the FSM SHALL arbitrate again at the same edge, using the requests present at that edge.
- Back-to-back accesses are allowed.
- Peak throughput: one access per cycle.
REQ-019 A requester that drops req before gnt SHALL withdraw cleanly; if req is not present at the arbitration edge, no access is issued for it.
REQ-020 x_rdata SHALL hold its last read value until the next read completes for that port.
REQ-021 The non-granted port SHALL see gnt=0 and rvalid=0.
REQ-022 mem_we SHALL be 0 in IDLE, and mem_addr/mem_wd SHALL hold their last values in IDLE.

Configuration
REQ-023 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin:
- A 1-bit last_grant register records the most recent grantee (0=CPU, 1=IO).
- On a tie, the port that is not last_grant wins.
- last_grant resets to 1, so the first tie goes to the CPU.
REQ-024 Without DMEM_ARB_RR_EN, the CPU SHALL always win a tie (fixed priority), and no last_grant register SHALL exist.

Reset
REQ-025 Asserting reset SHALL immediately force:
- state=IDLE;
- all gnt, rvalid and mem_we outputs to 0;
- mem_addr, mem_wd and all rdata outputs to 0;
- last_grant to 1.
REQ-026 A reset asserted during ACC_x SHALL abort the access:
- mem_we drops asynchronously, so no write commits.
- No rvalid is produced.
REQ-027 After reset deasserts, the first arbitration SHALL occur at the first clk edge with reset low.

Structure
REQ-028 A shared package dmem_arb_pkg SHALL hold:
- the state encoding (IDLE=2'd0, ACC_CPU=2'd1, ACC_IO=2'd2);
- the port index constants PORT_CPU=0 and PORT_IO=1.
REQ-029 The tie-break logic SHALL be a sub-module arb_pick (inputs: req_cpu, req_io, last_grant; output: winner), so that the configuration affects only that sub-module.

Verification
REQ-030 The bench SHALL cover a CPU-only read: cpu_addr=8'h10 with mem[16]=8'h5A -> cpu_gnt in cycle 1, then cpu_rvalid=1 with cpu_rdata=8'h5A in cycle 2.
REQ-031 The bench SHALL cover an IO write: io_addr=8'h20, io_wdata=8'hC3 -> mem_we=1 only during ACC_IO, then a CPU read of 8'h20 returns 8'hC3.
REQ-032 The bench SHALL cover both ports requesting continuously for 4 grants:
- RR_EN -> grants CPU, IO, CPU, IO.
- No RR_EN -> grants CPU four times with io_gnt never asserted.
REQ-033 The bench SHALL cover back-to-back CPU reads of 8'h01 and 8'h02 -> gnt in consecutive cycles, and rvalid in consecutive cycles with the matching data.
REQ-034 The bench SHALL cover reset asserted mid-ACC_IO during a write to 8'h30 (old value 8'h11) -> mem_we falls immediately, mem[48] stays 8'h11, and there is no rvalid.
REQ-035 The bench SHALL cover cpu_req pulsed for one cycle without being held while io_req is granted -> no CPU access and no cpu_gnt.
